// File: rtl/nvram_uploader.sv
// ============================================================================
//  Module   : nvram_uploader
//  Purpose  : Read-back (upload) server for the non-volatile / high-score RAM.
//             Answers HPS ioctl_rd requests for file index INDEX with bytes
//             from a read port of the score RAM, halting the game CPU while
//             the upload runs so the snapshot is consistent. Also turns a
//             rising edge of the OSD save option into a one-cycle upload
//             request towards the HPS.
//  Ports    : clk_sys, reset (sync, active-high)
//             ioctl_upload/index/addr/rd  -> request side from hps_io
//             ioctl_din, ioctl_wait       -> returned byte and stall
//             save_req -> ioctl_upload_req (save trigger)
//             ram_addr, ram_rd, ram_q     -> score RAM read port
//             pause_cpu, busy             -> CPU halt and activity status
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nvram_uploader #(
  parameter logic [7:0] INDEX     = 8'd4,
  parameter int         ADDR_W    = 10,
  parameter int         SIZE      = 1024,
  parameter int         RAM_LAT   = 2,
  parameter int         PAUSE_CYC = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  input  logic              save_req,
  output logic              ioctl_upload_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  output logic              pause_cpu,
  output logic              busy
);

  localparam int          CNT_W      = (PAUSE_CYC < 2) ? 1 : $clog2(PAUSE_CYC + 1);
  localparam logic [CNT_W-1:0] C_PAUSE = CNT_W'(PAUSE_CYC);
  localparam logic [2:0]  C_LAT      = 3'(RAM_LAT);
  localparam logic [25:0] C_SIZE     = 26'(SIZE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HALT  = 2'd1,
    S_READY = 2'd2,
    S_FETCH = 2'd3
  } state_t;

  state_t              r_state,      w_state_nxt;
  logic [CNT_W-1:0]    r_cnt,        w_cnt_nxt;
  logic [2:0]          r_lat,        w_lat_nxt;
  logic                r_pending,    w_pending_nxt;
  logic [ADDR_W-1:0]   r_pend_addr,  w_pend_addr_nxt;
  logic                r_pend_range, w_pend_range_nxt;
  logic                r_range,      w_range_nxt;
  logic [ADDR_W-1:0]   w_ram_addr_nxt;
  logic                w_ram_rd_nxt;
  logic [7:0]          w_din_nxt;
  logic                w_upload_req_nxt;

  logic r_upload_d;
  logic r_save_s1, r_save_s2, r_save_d;

  logic w_upload_rise;
  logic w_save_rise;
  logic w_in_range;

  assign w_upload_rise = ioctl_upload & ~r_upload_d;
  assign w_save_rise   = r_save_s2 & ~r_save_d;
  // Full 25-bit compare so high address bits can never alias into the RAM.
  assign w_in_range    = ({1'b0, ioctl_addr} < C_SIZE);

  assign busy       = (r_state != S_IDLE);
  assign pause_cpu  = busy;
  // A request parked during HALT keeps the HPS stalled until its byte lands.
  assign ioctl_wait = (r_state == S_FETCH) | r_pending;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_lat            <= '0;
      r_pending        <= 1'b0;
      r_pend_addr      <= '0;
      r_pend_range     <= 1'b0;
      r_range          <= 1'b0;
      ram_addr         <= '0;
      ram_rd           <= 1'b0;
      ioctl_din        <= 8'h00;
      ioctl_upload_req <= 1'b0;
      r_upload_d       <= 1'b0;
      r_save_s1        <= 1'b0;
      r_save_s2        <= 1'b0;
      r_save_d         <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_cnt            <= w_cnt_nxt;
      r_lat            <= w_lat_nxt;
      r_pending        <= w_pending_nxt;
      r_pend_addr      <= w_pend_addr_nxt;
      r_pend_range     <= w_pend_range_nxt;
      r_range          <= w_range_nxt;
      ram_addr         <= w_ram_addr_nxt;
      ram_rd           <= w_ram_rd_nxt;
      ioctl_din        <= w_din_nxt;
      ioctl_upload_req <= w_upload_req_nxt;
      r_upload_d       <= ioctl_upload;
      r_save_s1        <= save_req;
      r_save_s2        <= r_save_s1;
      r_save_d         <= r_save_s2;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_lat_nxt        = r_lat;
    w_pending_nxt    = r_pending;
    w_pend_addr_nxt  = r_pend_addr;
    w_pend_range_nxt = r_pend_range;
    w_range_nxt      = r_range;
    w_ram_addr_nxt   = ram_addr;
    w_ram_rd_nxt     = 1'b0;
    w_din_nxt        = ioctl_din;
    w_upload_req_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_upload_rise && (ioctl_index == INDEX)) begin
          w_state_nxt   = S_HALT;
          w_cnt_nxt     = C_PAUSE;
          w_pending_nxt = 1'b0;
        end
        if (w_save_rise) begin
          w_upload_req_nxt = 1'b1;
        end
      end

      S_HALT: begin
        if (ioctl_rd && !r_pending) begin
          w_pending_nxt    = 1'b1;
          w_pend_addr_nxt  = ioctl_addr[ADDR_W-1:0];
          w_pend_range_nxt = w_in_range;
        end
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = S_READY;
          // Launch the parked read so ram_rd lands in the first READY cycle;
          // pending stays set to keep ioctl_wait high through that cycle.
          if (r_pending || ioctl_rd) begin
            w_pending_nxt  = 1'b1;
            w_ram_addr_nxt = r_pending ? r_pend_addr : ioctl_addr[ADDR_W-1:0];
            w_range_nxt    = r_pending ? r_pend_range : w_in_range;
            w_ram_rd_nxt   = r_pending ? r_pend_range : w_in_range;
          end
        end
      end

      S_READY: begin
        if (r_pending) begin
          // RAM read already issued this cycle, so one latency step is spent.
          w_state_nxt   = S_FETCH;
          w_lat_nxt     = 3'd1;
          w_pending_nxt = 1'b0;
        end else if (ioctl_rd) begin
          w_state_nxt    = S_FETCH;
          w_lat_nxt      = 3'd0;
          w_ram_addr_nxt = ioctl_addr[ADDR_W-1:0];
          w_range_nxt    = w_in_range;
          w_ram_rd_nxt   = w_in_range;
        end
      end

      S_FETCH: begin
        if (r_lat == C_LAT) begin
          w_din_nxt   = r_range ? ram_q : 8'h00;
          w_state_nxt = S_READY;
        end else begin
          w_lat_nxt = r_lat + 3'd1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // HPS ended the upload: release the CPU and drop any in-flight fetch.
    if ((r_state != S_IDLE) && !ioctl_upload) begin
      w_state_nxt   = S_IDLE;
      w_pending_nxt = 1'b0;
      w_ram_rd_nxt  = 1'b0;
      w_din_nxt     = ioctl_din;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nvram_uploader.sv
// ============================================================================
//  Module   : tb_nvram_uploader
//  Purpose  : Self-checking bench for nvram_uploader with a scoreboard of
//             expected returned bytes and a RAM model of latency 2.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nvram_uploader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic        ioctl_rd;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        save_req;
  logic        ioctl_upload_req;
  logic [9:0]  ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_q;
  logic        pause_cpu;
  logic        busy;

  always #5 clk_sys = ~clk_sys;

  nvram_uploader dut (
    .clk_sys          (clk_sys),
    .reset            (reset),
    .ioctl_upload     (ioctl_upload),
    .ioctl_index      (ioctl_index),
    .ioctl_addr       (ioctl_addr),
    .ioctl_rd         (ioctl_rd),
    .ioctl_din        (ioctl_din),
    .ioctl_wait       (ioctl_wait),
    .save_req         (save_req),
    .ioctl_upload_req (ioctl_upload_req),
    .ram_addr         (ram_addr),
    .ram_rd           (ram_rd),
    .ram_q            (ram_q),
    .pause_cpu        (pause_cpu),
    .busy             (busy)
  );

  // RAM model: data appears 2 cycles after a ram_rd strobe; no strobe gives junk.
  logic [7:0] mem [0:1023];
  logic [7:0] r_q1, r_q2;
  always_ff @(posedge clk_sys) begin
    r_q1 <= ram_rd ? mem[ram_addr] : 8'hEE;
    r_q2 <= r_q1;
  end
  assign ram_q = r_q2;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [24:0] a);
    if (a < 25'd1024) return mem[a[9:0]];
    return 8'h00;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " din"},       32'(ioctl_din),        32'h00);
    check({tag, " wait"},      32'(ioctl_wait),       32'h0);
    check({tag, " uploadreq"}, 32'(ioctl_upload_req), 32'h0);
    check({tag, " ram_addr"},  32'(ram_addr),         32'h0);
    check({tag, " ram_rd"},    32'(ram_rd),           32'h0);
    check({tag, " pause"},     32'(pause_cpu),        32'h0);
    check({tag, " busy"},      32'(busy),             32'h0);
  endtask

  // Read issued in READY at cycle T; expects wait over T+1..T+3, din at T+4.
  task automatic do_read(input string tag, input logic [24:0] a);
    int         n;
    int         rds;
    logic [7:0] e;
    logic       inr;
    inr = (a < 25'd1024);
    exp_q.push_back(model(a));
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    step();
    ioctl_rd = 1'b0;
    check({tag, " wait@T+1"}, 32'(ioctl_wait), 32'h1);
    if (inr) check({tag, " ram_addr"}, 32'(ram_addr), 32'(a[9:0]));
    rds = int'(ram_rd);
    n   = 0;
    while (ioctl_wait && n < 20) begin
      step();
      n++;
      if (ioctl_wait) rds += int'(ram_rd);
    end
    check({tag, " latency"}, 32'(n), 32'd3);
    check({tag, " ram_rd count"}, 32'(rds), inr ? 32'd1 : 32'd0);
    e = exp_q.pop_front();
    check({tag, " din"}, 32'(ioctl_din), 32'(e));
  endtask

  initial begin
    int         n;
    int         rd_at;
    logic       pause_ok;
    int         seen;
    logic [7:0] e;

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[5] = 8'hA7;

    reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd4; ioctl_addr = '0;
    ioctl_rd = 1'b0; save_req = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    repeat (20) step();
    check_reset_outputs("idle");

    // Upload with index 4.
    ioctl_upload = 1'b1;
    step();
    check("start pause", 32'(pause_cpu), 32'h1);
    check("start busy",  32'(busy),      32'h1);
    repeat (16) step();
    do_read("rd5",     25'h005);
    do_read("rd1024",  25'd1024);
    do_read("rdalias", 25'h10005);
    do_read("rd1023",  25'd1023);

    // Abort mid-FETCH: din must keep the last returned byte (mem[1023]).
    ioctl_addr = 25'h005; ioctl_rd = 1'b1;
    step();
    ioctl_rd = 1'b0;
    step();
    ioctl_upload = 1'b0;
    step();
    check("abort pause", 32'(pause_cpu), 32'h0);
    check("abort wait",  32'(ioctl_wait), 32'h0);
    check("abort busy",  32'(busy),      32'h0);
    check("abort din",   32'(ioctl_din), 32'h5A ^ 32'hFF);
    repeat (3) step();
    check("abort din later", 32'(ioctl_din), 32'hA5);

    // Read issued during HALT (3 cycles after upload start).
    ioctl_upload = 1'b1;
    ioctl_addr   = 25'h007;
    step();
    step();
    step();
    ioctl_rd = 1'b1;
    exp_q.push_back(model(25'h007));
    step();
    ioctl_rd = 1'b0;
    check("halt wait", 32'(ioctl_wait), 32'h1);
    n = 0; rd_at = -1; pause_ok = 1'b1;
    while (ioctl_wait && n < 40) begin
      if (ram_rd) rd_at = n;
      if (!pause_cpu) pause_ok = 1'b0;
      step();
      n++;
    end
    check("halt wait length", 32'(n),        32'd16);
    check("halt ram_rd cycle", 32'(rd_at),   32'd13);
    check("halt pause held",  32'(pause_ok), 32'h1);
    e = exp_q.pop_front();
    check("halt din", 32'(ioctl_din), 32'(e));
    ioctl_upload = 1'b0;
    step();
    check("end busy", 32'(busy), 32'h0);

    // Foreign index is ignored.
    ioctl_index  = 8'd0;
    ioctl_upload = 1'b1;
    step();
    check("idx0 pause", 32'(pause_cpu), 32'h0);
    ioctl_addr = 25'h005; ioctl_rd = 1'b1;
    step();
    ioctl_rd = 1'b0;
    seen = int'(ram_rd) + int'(ioctl_wait);
    repeat (4) begin
      step();
      seen += int'(ram_rd) + int'(ioctl_wait);
    end
    check("idx0 no activity", 32'(seen), 32'd0);
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd4;
    step();

    // Save request in IDLE: pulse 3 cycles after the rise.
    save_req = 1'b1;
    step();
    check("save +1", 32'(ioctl_upload_req), 32'h0);
    step();
    check("save +2", 32'(ioctl_upload_req), 32'h0);
    step();
    check("save +3", 32'(ioctl_upload_req), 32'h1);
    step();
    check("save +4", 32'(ioctl_upload_req), 32'h0);
    save_req = 1'b0;
    repeat (4) step();

    // Save request while busy is dropped.
    ioctl_upload = 1'b1;
    step();
    save_req = 1'b1;
    seen = 0;
    repeat (8) begin
      step();
      seen += int'(ioctl_upload_req);
    end
    check("save busy", 32'(seen), 32'd0);
    save_req = 1'b0;
    repeat (12) step();

    // Reset mid-FETCH.
    ioctl_addr = 25'h005; ioctl_rd = 1'b1;
    step();
    ioctl_rd = 1'b0;
    check("pre-reset wait", 32'(ioctl_wait), 32'h1);
    step();
    reset = 1'b1;
    step();
    check_reset_outputs("reset fetch");
    reset        = 1'b0;
    ioctl_upload = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nvram_uploader.md
# nvram_uploader

Serves HPS upload (read-back) requests for the non-volatile/high-score RAM. It is the reading end of the ioctl file-transfer interface: the ROM/DIP path handles HPS-to-core writes, and this block returns core RAM bytes to the HPS on `ioctl_rd`. It sits between `hps_io` and a read port of the game's score RAM. While an upload runs it halts the game CPU so the snapshot stays consistent.

## Interface
Parameters:
- INDEX, 8'd4 — ioctl_index value this block answers.
- ADDR_W, 10 — RAM address width.
- SIZE, 1024 — number of valid bytes; must be ≤ 2^ADDR_W.
- RAM_LAT, 2 — cycles from `ram_rd` to valid `ram_q` (1..7).
- PAUSE_CYC, 16 — cycles allowed for the CPU to halt after `pause_cpu` rises.

Ports (clock clk_sys; reset is synchronous, active-high):
- clk_sys  in  1  system clock (24.576 MHz)
- reset  in  1  synchronous active-high reset
- ioctl_upload  in  1  HPS upload in progress
- ioctl_index  in  8  file index of the transfer
- ioctl_addr  in  25  byte address of the request
- ioctl_rd  in  1  one-cycle read request
- ioctl_din  out  8  returned byte
- ioctl_wait  out  1  HPS must stall while high
- save_req  in  1  level from the OSD save option; the rising edge requests an upload
- ioctl_upload_req  out  1  one-cycle request to the HPS to start an upload
- ram_addr  out  ADDR_W  RAM read address
- ram_rd  out  1  one-cycle RAM read strobe
- ram_q  in  8  RAM read data
- pause_cpu  out  1  halt request to the game CPU
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, HALT, READY, FETCH.
- IDLE
  - A rising edge of `ioctl_upload` with `ioctl_index==INDEX` → HALT. `pause_cpu`=1 and the pause counter loads PAUSE_CYC.
  - Any other index is ignored: no output changes.
- HALT
  - The counter decrements each cycle. At 0 → READY.
  - An `ioctl_rd` arriving in HALT is latched as pending. `ioctl_wait`=1 from the following cycle.
- READY
  - On `ioctl_rd` (or a pending request on entry), capture `ioctl_addr[ADDR_W-1:0]` into `ram_addr` and go to FETCH.
  - Pulse `ram_rd` for one cycle, but only if `ioctl_addr < SIZE`.
- FETCH
  - Count RAM_LAT cycles, then register `ioctl_din <= ram_q` if the address was < SIZE, else 8'h00. Return to READY.
- `ioctl_wait`=1 from the cycle after `ioctl_rd` until the cycle `ioctl_din` updates; it drops the same cycle.
- `ioctl_rd` during FETCH is a protocol error. It is ignored and causes no state change.
- A falling `ioctl_upload` in any non-IDLE state → IDLE next cycle.
  - `pause_cpu`=0 and `ioctl_wait`=0; any in-flight fetch is abandoned.
  - `ioctl_din` holds its last value.
- Save request: a rising edge of `save_req` in IDLE gives `ioctl_upload_req`=1 for exactly one cycle.
  - Edges seen while `busy` are dropped, not queued.
  - `save_req` is double-registered before edge detection.
- Address comparison uses the full 25-bit `ioctl_addr` against SIZE. Bits above ADDR_W never alias into RAM.

## Timing
- Reset values: `ioctl_din`=8'h00, `ioctl_wait`=0, `ioctl_upload_req`=0, `ram_addr`=0, `ram_rd`=0, `pause_cpu`=0, `busy`=0, state IDLE. The pause counter, pending flag and edge-detector registers also clear.
- Reset asserted mid-upload forces every output to its reset value on the next edge, regardless of `ioctl_upload`.
- Upload start: `pause_cpu` and `busy` rise 1 cycle after the `ioctl_upload` rising edge is sampled.
- HALT lasts exactly PAUSE_CYC cycles.
- Read latency in READY: `ioctl_rd` at cycle T.
  - `ram_rd` at T+1.
  - `ioctl_din` valid at T+2+RAM_LAT.
  - `ioctl_wait` high over T+1..T+1+RAM_LAT.
- Back-to-back reads: the next `ioctl_rd` may be accepted the cycle after `ioctl_din` updates.
- A pending read from HALT is issued in the first READY cycle (`ram_rd` that cycle).

## Test plan
- Reset, then idle 20 cycles → all outputs at reset values; `busy`=0.
- Upload with index 4, PAUSE_CYC=16; `ioctl_rd` at addr 0x005 once READY, RAM[5]=8'hA7, RAM_LAT=2 → `ram_rd` at T+1 with `ram_addr`=5; `ioctl_din`=8'hA7 at T+4; `ioctl_wait` high exactly over T+1..T+3.
- `ioctl_rd` issued 3 cycles after upload start (during HALT) → `ioctl_wait` held high until HALT ends plus RAM_LAT+1; correct byte returned; `pause_cpu`=1 throughout.
- Reads at addr 1023 and 1024 with SIZE=1024 → RAM[1023] is returned. Addr 1024 gives 8'h00 with no `ram_rd` pulse but the same latency. Addr 0x10005 gives 8'h00 (no alias to RAM[5]).
- Upload with index 0 → `pause_cpu` stays 0 and `ioctl_rd` produces no `ram_rd`. Drop `ioctl_upload` mid-FETCH on an index-4 upload → `pause_cpu`/`ioctl_wait` fall next cycle and `ioctl_din` is unchanged.
- `save_req` rise in IDLE → one-cycle `ioctl_upload_req` 3 cycles later. `save_req` rise during an upload → no pulse. Assert reset mid-FETCH → all outputs at reset values next edge.
